dmem_responder: RTL and testbench

Responder end of the pipeline's MEM-stage data-memory interface. It accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It returns a single-cycle response carrying read data. The MEM stage holds its request until it is accepted and consumes the response in the cycle it is asserted.

---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
// Optional misaligned-address rejection is enabled with DMEM_ALIGN_CHECK_EN.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W           = 4;
  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read, no reset.
// The read register only updates on a read, so it holds between accesses.
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, WAIT_CYCLES wait states,
// single-cycle response. `define DMEM_ALIGN_CHECK_EN to reject misaligned addresses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             mis_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;
  logic             err_q;
  logic             zero_q;

  logic             req_mis;
  logic             unused_addr;
  logic             cur_write;
  logic [AW-1:0]    cur_idx;
  logic [31:0]      cur_wdata;
  logic             cur_mis;
  logic             access_fire;
  logic [31:0]      arr_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis     = |req_addr_i[1:0];
  assign unused_addr = ^req_addr_i[31:AW+2];
`else
  assign req_mis     = 1'b0;
  assign unused_addr = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};
`endif

  // With no wait states the access happens on the acceptance edge, straight from the request.
  always_comb begin
    cur_write = write_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_mis   = mis_q;
    if (state_q == IDLE) begin
      cur_write = req_write_i;
      cur_idx   = req_addr_i[AW+1:2];
      cur_wdata = req_wdata_i;
      cur_mis   = req_mis;
    end
  end

  assign access_fire = ((state_q == IDLE) && req_valid_i && NO_WAIT) ||
                       ((state_q == WAIT) && (cnt_q == '0));

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (access_fire & ~cur_mis & rst_n),
    .we_i   (cur_write),
    .addr_i (cur_idx),
    .wdata_i(cur_wdata),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            idx_q   <= req_addr_i[AW+1:2];
            wdata_q <= req_wdata_i;
            mis_q   <= req_mis;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (NO_WAIT) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              err_q   <= req_mis;
              zero_q  <= req_write_i | req_mis;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            err_q   <= mis_q;
            zero_q  <= write_q | mis_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stores and rejected accesses report zero data; the array register keeps the last load.
  assign resp_rdata_o = zero_q ? 32'h0 : arr_rdata;
  assign resp_err_o   = err_q;
  assign resp_valid_o = valid_q;
  assign req_ready_o  = ready_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states and one
// with none, checked against a word-array reference model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        v2, r2, rv2, e2, b2;
  logic        v0, r0, rv0, e0, b0;
  logic [31:0] rd2, rd0;
  logic        ready_m, resp_valid_m, err_m, busy_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] ref_mem [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v2 = req_valid & ~sel;
  assign v0 = req_valid & sel;
  assign ready_m      = sel ? r0  : r2;
  assign resp_valid_m = sel ? rv0 : rv2;
  assign err_m        = sel ? e0  : e2;
  assign busy_m       = sel ? b0  : b2;
  assign rdata_m      = sel ? rd0 : rd2;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_n(rst_n), .req_valid_i(v2), .req_ready_o(r2),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(rv2), .resp_rdata_o(rd2), .resp_err_o(e2), .busy_o(b2)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_n(rst_n), .req_valid_i(v0), .req_ready_o(r0),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(rv0), .resp_rdata_o(rd0), .resp_err_o(e0), .busy_o(b0)
  );

  function automatic int word_of(input logic [31:0] a);
    return int'(a[31:2]) % DEPTH;
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction on the selected instance; early=1 drives in the current
  // (response) cycle so the request is held through RESP.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit early, output int acc_cyc);
    int wc, tmo, lat, idx;
    bit got, mis, hold_ok;
    logic [31:0] exp_rd;
    logic exp_err;
    wc = sel ? 0 : 2;
    idx = word_of(addr);
    mis = misaligned(addr);
    exp_err = mis;
    exp_rd = (wr || mis) ? 32'h0 : ref_mem[sel][idx];
    if (!early) @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    tmo = 0;
    while (ready_m !== 1'b1 && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    checks++;
    if (ready_m !== 1'b1) begin
      errors++;
      $display("FAIL accept: ready=%b after %0d cycles, required 1", ready_m, tmo);
      req_valid = 1'b0;
      acc_cyc = cyc;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    if (wr && !mis) ref_mem[sel][idx] = wdata;
    lat = 0;
    got = 1'b0;
    hold_ok = 1'b1;
    while (!got && lat < wc + 4) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (resp_valid_m === 1'b1) got = 1'b1;
      if (busy_m !== 1'b1 || ready_m !== 1'b0) hold_ok = 1'b0;
    end
    checks++;
    if (!got || lat != wc + 1) begin
      errors++;
      $display("FAIL latency sel=%0d addr=%h: got=%0d lat=%0d, required lat=%0d", sel, addr, got, lat, wc + 1);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL busy_ready sel=%0d addr=%h: busy/ready not 1/0 while in flight", sel, addr);
    end
    checks++;
    if (rdata_m !== exp_rd) begin
      errors++;
      $display("FAIL rdata sel=%0d wr=%0d addr=%h: got %h, required %h", sel, wr, addr, rdata_m, exp_rd);
    end
    checks++;
    if (err_m !== exp_err) begin
      errors++;
      $display("FAIL err sel=%0d addr=%h: got %b, required %b", sel, addr, err_m, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL reset_ready sel=%0d: got %b, required 1", s, ready_m); end
      checks++; if (resp_valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid sel=%0d: got %b, required 0", s, resp_valid_m); end
      checks++; if (rdata_m !== 32'h0) begin errors++; $display("FAIL reset_rdata sel=%0d: got %h, required 0", s, rdata_m); end
      checks++; if (err_m !== 1'b0) begin errors++; $display("FAIL reset_err sel=%0d: got %b, required 0", s, err_m); end
      checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy sel=%0d: got %b, required 0", s, busy_m); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init_mem();
    int acc;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      do_txn(1'b1, 32'h0, $urandom, 1'b0, acc);
      for (int i = 1; i < DEPTH; i++) do_txn(1'b1, 32'(i * 4), $urandom, 1'b1, acc);
    end
  endtask

  task automatic test_basic();
    int acc;
    sel = 1'b0;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, acc);
    do_txn(1'b0, 32'h10, 32'h0, 1'b0, acc);
    repeat (2) @(negedge clk);
    checks++;
    if (rdata_m !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rdata_hold: got %h, required deadbeef", rdata_m);
    end
  endtask

  task automatic test_back_to_back();
    int prev, acc;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      do_txn(1'b0, 32'(($urandom % DEPTH) * 4), 32'h0, 1'b0, prev);
      for (int k = 0; k < 4; k++) begin
        do_txn(1'b0, 32'(($urandom % DEPTH) * 4), 32'h0, 1'b1, acc);
        checks++;
        if (acc - prev != (s ? 2 : 4)) begin
          errors++;
          $display("FAIL b2b_spacing sel=%0d: got %0d cycles, required %0d", s, acc - prev, s ? 2 : 4);
        end
        prev = acc;
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    sel = 1'b0;
    do_txn(1'b1, 32'h400, 32'h12345678, 1'b0, acc);
    do_txn(1'b0, 32'h0, 32'h0, 1'b0, acc);
    checks++;
    if (rdata_m !== 32'h12345678) begin
      errors++;
      $display("FAIL wrap: got %h, required 12345678", rdata_m);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit seen;
    sel = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy_m !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy_m); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_m !== 1'b0 || ready_m !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_idle: busy=%b ready=%b, required 0/1", busy_m, ready_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid_m !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_resp: resp_valid seen 1, required 0"); end
    do_txn(1'b0, 32'h20, 32'h0, 1'b0, acc);
    do_txn(1'b1, 32'h24, 32'h5A5A0FF0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid_m !== 1'b0) begin errors++; $display("FAIL resp_reset_valid: got %b, required 0", resp_valid_m); end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h24, 32'h0, 1'b0, acc);
  endtask

  task automatic test_align();
    int acc;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      do_txn(1'b1, 32'h13, 32'hCAFEF00D, 1'b0, acc);
      do_txn(1'b0, 32'h10, 32'h0, 1'b0, acc);
      do_txn(1'b0, 32'h11, 32'h0, 1'b0, acc);
    end
  endtask

  task automatic test_random();
    int acc;
    for (int k = 0; k < 80; k++) begin
      sel = 1'($urandom_range(0, 1));
      do_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFF)), $urandom, 1'b0, acc);
    end
  endtask

  initial begin
    test_reset();
    test_init_mem();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
